// File: rtl/brq_pkg.sv
// rtl/brq_pkg.sv - shared types and constants for the branch resolve queue
package brq_pkg;

    localparam int PC_MAX_W = 32;
    localparam int unsigned PC_INC = 4;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    // Entry fields are sized for the widest supported PC; narrower PCs are zero-extended.
    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic                pred_taken;
        logic [PC_MAX_W-1:0] pred_tgt;
    } entry_t;

endpackage

// File: rtl/brq_fifo.sv
// rtl/brq_fifo.sv - circular entry store with wrapping pointers, occupancy count and synchronous clear
module brq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-flight branch tracker producing BHT training writes and mispredict flushes
// Optional macro BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int IDX_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [PC_W-1:0]          push_pc,
    input  logic                     push_pred_taken,
    input  logic [PC_W-1:0]          push_pred_tgt,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [PC_W-1:0]          res_tgt,
    output logic                     upd_valid,
    output logic [IDX_W-1:0]         upd_addr,
    output logic                     upd_taken,
    output logic                     flush,
    output logic [PC_W-1:0]          redirect_pc,
    output logic                     res_err,
`ifdef BRQ_STATS_EN
    output logic [31:0]              stat_resolved,
    output logic [31:0]              stat_mispred,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    state_t         state;
    state_t         state_next;
    entry_t         push_entry;
    entry_t         head;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] head_tgt;
    logic           push_fire;
    logic           res_fire;
    logic           empty_res;
    logic           mispred;

    assign push_entry = '{pc:         PC_MAX_W'(push_pc),
                          pred_taken: push_pred_taken,
                          pred_tgt:   PC_MAX_W'(push_pred_tgt)};
    assign head_pc  = head.pc[PC_W-1:0];
    assign head_tgt = head.pred_tgt[PC_W-1:0];
    assign mispred  = (head.pred_taken != res_taken) || (res_taken && (head_tgt != res_tgt));

    // A mispredict clears the store, which also swallows any same-cycle push.
    brq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_fire && !(res_fire && mispred)),
        .push_data (push_entry),
        .pop       (res_fire && !mispred),
        .clear     (res_fire && mispred),
        .head_data (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (res_fire && mispred) state_next = RECOVER;
            RECOVER: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        push_ready = (state == RUN) && (count < FULL);
        push_fire  = push_valid && push_ready;
        res_fire   = (state == RUN) && res_valid && (count != '0);
        empty_res  = (state == RUN) && res_valid && (count == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_valid   <= 1'b0;
            upd_addr    <= '0;
            upd_taken   <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            res_err     <= 1'b0;
        end else begin
            upd_valid <= res_fire;
            flush     <= res_fire && mispred;
            res_err   <= empty_res;
            if (res_fire) begin
                upd_addr  <= head.pc[IDX_W+1:2];
                upd_taken <= res_taken;
            end
            if (res_fire && mispred) begin
                redirect_pc <= res_taken ? res_tgt : head_pc + PC_W'(PC_INC);
            end
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (res_fire && (stat_resolved != 32'hFFFF_FFFF)) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (res_fire && mispred && (stat_mispred != 32'hFFFF_FFFF)) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - self-checking bench for branch_resolve_queue with a queue-based reference model
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_pc = '0;
    logic        push_pred_taken = 1'b0;
    logic [31:0] push_pred_tgt = '0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_tgt = '0;
    logic        upd_valid;
    logic [4:0]  upd_addr;
    logic        upd_taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        res_err;
    logic [2:0]  count;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(32), .IDX_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .push_valid      (push_valid),
        .push_ready      (push_ready),
        .push_pc         (push_pc),
        .push_pred_taken (push_pred_taken),
        .push_pred_tgt   (push_pred_tgt),
        .res_valid       (res_valid),
        .res_taken       (res_taken),
        .res_tgt         (res_tgt),
        .upd_valid       (upd_valid),
        .upd_addr        (upd_addr),
        .upd_taken       (upd_taken),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .res_err         (res_err),
`ifdef BRQ_STATS_EN
        .stat_resolved   (stat_resolved),
        .stat_mispred    (stat_mispred),
`endif
        .count           (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of in-flight branches plus a one-cycle recover flag.
    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ment_t;

    ment_t       mq[$];
    ment_t       mh;
    ment_t       mn;
    bit          m_rec = 0;
    bit          started = 0;
    bit          m_ready;
    bit          m_mis;
    logic        e_upd_valid, e_upd_taken, e_flush, e_err;
    logic [4:0]  e_upd_addr;
    logic [31:0] e_redirect;
    logic [31:0] m_nres, m_nmis;

    always @(posedge clk) begin
        mn = '{pc: push_pc, pt: push_pred_taken, tgt: push_pred_tgt};
        if (!rst_n) begin
            mq.delete();
            m_rec = 0;
            started = 1;
            {e_upd_valid, e_upd_taken, e_flush, e_err} = 4'b0;
            e_upd_addr = '0;
            e_redirect = '0;
            m_nres = 0;
            m_nmis = 0;
        end else begin
            e_upd_valid = 0;
            e_flush = 0;
            e_err = 0;
            if (m_rec) begin
                m_rec = 0;
            end else begin
                m_ready = mq.size() < DEPTH;
                if (res_valid && mq.size() == 0) begin
                    e_err = 1;
                    if (push_valid) mq.push_back(mn);
                end else if (res_valid) begin
                    mh = mq[0];
                    m_mis = (mh.pt != res_taken) || (res_taken && mh.tgt != res_tgt);
                    e_upd_valid = 1;
                    e_upd_addr = mh.pc[6:2];
                    e_upd_taken = res_taken;
                    m_nres++;
                    if (m_mis) begin
                        e_flush = 1;
                        e_redirect = res_taken ? res_tgt : mh.pc + 32'd4;
                        mq.delete();
                        m_rec = 1;
                        m_nmis++;
                    end else begin
                        void'(mq.pop_front());
                        if (push_valid && m_ready) mq.push_back(mn);
                    end
                end else if (push_valid && m_ready) begin
                    mq.push_back(mn);
                end
            end
        end
        #1;
        if (started) begin
            chk("upd_valid", 32'(upd_valid), 32'(e_upd_valid));
            chk("upd_addr", 32'(upd_addr), 32'(e_upd_addr));
            chk("upd_taken", 32'(upd_taken), 32'(e_upd_taken));
            chk("flush", 32'(flush), 32'(e_flush));
            chk("redirect_pc", redirect_pc, e_redirect);
            chk("res_err", 32'(res_err), 32'(e_err));
            chk("count", 32'(count), mq.size());
            chk("push_ready", 32'(push_ready), 32'(!m_rec && mq.size() < DEPTH));
`ifdef BRQ_STATS_EN
            chk("stat_resolved", stat_resolved, m_nres);
            chk("stat_mispred", stat_mispred, m_nmis);
`endif
        end
    end

    task automatic cycle(input logic pv, input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                         input logic rv, input logic rt, input logic [31:0] rtgt);
        @(negedge clk);
        push_valid = pv;
        push_pc = pc;
        push_pred_taken = pt;
        push_pred_tgt = ptgt;
        res_valid = rv;
        res_taken = rt;
        res_tgt = rtgt;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0;
        idle();
        idle();
        chk("rst_count", 32'(count), 0);
        chk("rst_push_ready", 32'(push_ready), 0 + 1);
        chk("rst_upd_valid", 32'(upd_valid), 0);
        rst_n = 1;

        // 1: single correct not-taken branch
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("t1_upd_valid", 32'(upd_valid), 1);
        chk("t1_upd_addr", 32'(upd_addr), 16);
        chk("t1_upd_taken", 32'(upd_taken), 0);
        chk("t1_flush", 32'(flush), 0);
        chk("t1_count", 32'(count), 0);

        // 2: fill to DEPTH, then resolve while fetch keeps offering
        for (int i = 0; i < 4; i++) cycle(1, 32'h100 + 32'(4 * i), 0, 0, 0, 0, 0);
        chk("t2_full_count", 32'(count), 4);
        chk("t2_full_ready", 32'(push_ready), 0);
        cycle(1, 32'h110, 0, 0, 1, 0, 0);
        chk("t2_count", 32'(count), 3);
        chk("t2_ready", 32'(push_ready), 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        chk("t2_last_addr", 32'(upd_addr), 32'h10C >> 2 & 32'h1F);

        // 3: taken with wrong target
        cycle(1, 32'h10, 1, 32'h80, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 32'h84);
        chk("t3_flush", 32'(flush), 1);
        chk("t3_redirect", redirect_pc, 32'h84);
        chk("t3_upd_taken", 32'(upd_taken), 1);
        chk("t3_recover_ready", 32'(push_ready), 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("t3_run_ready", 32'(push_ready), 1);
        chk("t3_ignored_err", 32'(res_err), 0);
        chk("t3_ignored_upd", 32'(upd_valid), 0);

        // 4: head predicted taken, actually not taken; younger entries and same-cycle push dropped
        cycle(1, 32'h20, 1, 32'h200, 0, 0, 0);
        cycle(1, 32'h24, 0, 0, 0, 0, 0);
        cycle(1, 32'h28, 0, 0, 0, 0, 0);
        cycle(1, 32'h2C, 0, 0, 1, 0, 0);
        chk("t4_redirect", redirect_pc, 32'h24);
        chk("t4_count", 32'(count), 0);
        chk("t4_flush", 32'(flush), 1);
        idle();
        chk("t4_flush_pulse", 32'(flush), 0);

        // 5: resolve with nothing in flight
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("t5_err", 32'(res_err), 1);
        chk("t5_upd", 32'(upd_valid), 0);
        chk("t5_flush", 32'(flush), 0);
        cycle(1, 32'h30, 0, 0, 1, 0, 0);
        chk("t5_push_err", 32'(res_err), 1);
        chk("t5_push_count", 32'(count), 1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("t5_addr", 32'(upd_addr), 12);

        // reset with a resolve pending
        cycle(1, 32'h50, 0, 0, 0, 0, 0);
        rst_n = 0;
        cycle(0, 0, 0, 0, 1, 1, 0);
        chk("rst_mid_upd", 32'(upd_valid), 0);
        chk("rst_mid_count", 32'(count), 0);
        rst_n = 1;

        // 6: nine overlapped push/resolve pairs across pointer wrap
        cycle(1, 32'h200, 0, 0, 0, 0, 0);
        for (int i = 1; i < 9; i++) begin
            cycle(1, 32'h200 + 32'(8 * i), 0, 0, 1, 0, 0);
            chk("t6_addr", 32'(upd_addr), 32'(2 * (i - 1)));
        end
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("t6_addr_last", 32'(upd_addr), 16);
        chk("t6_count", 32'(count), 0);
`ifdef BRQ_STATS_EN
        chk("t6_stat_resolved", stat_resolved, 9);
        chk("t6_stat_mispred", stat_mispred, 0);
`endif
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
